riscv_rf_wb_arb: RTL
====================

RISCV_RF_WB_ARB -- requirements
Module: riscv_rf_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 2, meaning the number of consecutive cycles the LSU may be refused before it takes priority (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port alu_wb_valid_i, input, 1, ALU writeback present this cycle; it cannot be back-pressured.
REQ-005 SHALL have port alu_wb_dst_i, input, 5 (rsd_t), ALU destination register.
REQ-006 SHALL have port alu_wb_data_i, input, 32, ALU writeback data.
REQ-007 SHALL have ports lsu_wb_valid_i (input, 1), lsu_wb_dst_i (input, 5), lsu_wb_data_i (input, 32), lsu_wb_ready_o (output, 1), forming the LSU load-return valid/ready channel.
REQ-008 SHALL have ports lsu_issue_i (input, 1) and lsu_issue_dst_i (input, 5), a load issued this cycle and its destination.
REQ-009 SHALL have ports rf_src1_i and rf_src2_i, input, 5 each, the decode-stage source indices.
REQ-010 SHALL have ports rf_we_o (output, 1), rf_dst_o (output, 5) and rf_dst_d_o (output, 32), driving the register-file write port.
REQ-011 SHALL have port wb_stall_o, output, 1, requesting that the pipeline present no ALU writeback next cycle.
REQ-012 SHALL have port raw_stall_o, output, 1, indicating a decode source depends on an outstanding load.

Function
REQ-013 State: hold register (hold_valid, hold_dst, hold_data), starve_cnt (3 bits, saturating at STARVE_LIMIT), pending[31:0] load scoreboard.
REQ-014 Grant is combinational, with priority evaluated in this order:
- (a) hold_valid -> write hold.
- (b) lsu_wb_valid_i && starve_cnt==STARVE_LIMIT -> write LSU.
- (c) alu_wb_valid_i -> write ALU.
- (d) lsu_wb_valid_i -> write LSU.
- (e) otherwise no write.
REQ-015 Under case (b) with alu_wb_valid_i=1, the ALU dst/data SHALL be captured into the hold register at the clock edge and written the next cycle via case (a).
REQ-016 The write port SHALL carry the granted source's dst/data in the same cycle; rf_we_o=1 only if a source is granted and its dst!=x0.
REQ-017 A granted write to x0 SHALL be consumed (handshake completes, LSU pending logic runs) but rf_we_o SHALL stay 0.
REQ-018 lsu_wb_ready_o=1 exactly when the LSU is granted (case b or d); a transfer occurs on lsu_wb_valid_i && lsu_wb_ready_o.
REQ-019 The LSU SHALL hold valid/dst/data stable until the transfer occurs.
REQ-020 wb_stall_o SHALL equal the next-cycle hold_valid, i.e. it is asserted in the case-(b)-with-ALU cycle.
REQ-021 alu_wb_valid_i=1 while hold_valid=1 is a protocol violation; the bench SHALL flag it with an assertion.
REQ-022 starve_cnt SHALL:
- increment (saturating) when lsu_wb_valid_i=1 without transfer;
- clear on a transfer;
- hold when lsu_wb_valid_i=0.
REQ-023 pending[d] SHALL set on lsu_issue_i with d=lsu_issue_dst_i!=0, and clear on an LSU transfer to d.
REQ-024 On simultaneous set and clear of the same index, set SHALL win; pending[0] SHALL remain 0.
REQ-025 raw_stall_o = (rf_src1_i!=0 && pending[rf_src1_i]) || (rf_src2_i!=0 && pending[rf_src2_i]), computed from registered state only.
REQ-026 Consecutive writes to the same dst SHALL commit in grant order; a held ALU value SHALL never be overtaken by a later ALU write.

Reset
REQ-027 While rst=1, all of the following SHALL hold during that cycle and the state SHALL be cleared at the edge:
- rf_we_o=0, lsu_wb_ready_o=0, wb_stall_o=0, raw_stall_o=0;
- hold_valid=0, starve_cnt=0, pending=0.
REQ-028 Reset asserted mid-hold or mid-starvation SHALL discard the held data and the pending load with no write.
REQ-029 In the first cycle after reset, the grant SHALL follow REQ-014 with cleared state.

Verification
REQ-030 alu_wb_valid_i=1 with dst=5, data=0x11 -> same-cycle rf_we_o=1, rf_dst_o=5, rf_dst_d_o=0x11.
REQ-031 ALU dst=3 data=0xA and LSU dst=7 data=0xB presented every cycle, STARVE_LIMIT=2 -> expected sequence:
- ALU writes in cycles 0-1;
- cycle 2: LSU writes (ready=1), ALU captured to hold, wb_stall_o=1;
- cycle 3: hold writes dst=3 data=0xA.
REQ-032 lsu_issue_i with dst=9, then rf_src1_i=9 -> raw_stall_o=1 from the next cycle until the cycle after the LSU transfer to 9; rf_src2_i=0 never stalls.
REQ-033 LSU transfer to dst=0 with data=0xFF -> lsu_wb_ready_o=1, rf_we_o=0, starve_cnt cleared.
REQ-034 Same-cycle lsu_issue_i dst=4 and LSU transfer dst=4 -> pending[4]=1 afterwards.
REQ-035 rst asserted in the cycle after hold capture -> no hold write, all outputs 0 the following cycle.

Source files
------------

// File: rtl/riscv_rf_wb_arb.sv
// Register-file writeback arbiter: merges the ALU and LSU writebacks onto one port,
// with LSU anti-starvation, a one-entry ALU hold register and a load RAW scoreboard.
module riscv_rf_wb_arb #(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_wb_valid_i,
    input  logic [4:0]  alu_wb_dst_i,
    input  logic [31:0] alu_wb_data_i,
    input  logic        lsu_wb_valid_i,
    input  logic [4:0]  lsu_wb_dst_i,
    input  logic [31:0] lsu_wb_data_i,
    output logic        lsu_wb_ready_o,
    input  logic        lsu_issue_i,
    input  logic [4:0]  lsu_issue_dst_i,
    input  logic [4:0]  rf_src1_i,
    input  logic [4:0]  rf_src2_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_dst_o,
    output logic [31:0] rf_dst_d_o,
    output logic        wb_stall_o,
    output logic        raw_stall_o
);

    typedef logic [4:0] rsd_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_HOLD, GNT_LSU, GNT_ALU} grant_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic        hold_valid_q, hold_valid_d;
    rsd_t        hold_dst_q,   hold_dst_d;
    logic [31:0] hold_data_q,  hold_data_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] pending_q,    pending_d;

    grant_e      grant;
    logic        starve_hit;
    logic        lsu_xfer;
    logic        capture;
    rsd_t        wb_dst;
    logic [31:0] wb_data;

    assign starve_hit = (starve_cnt_q == LIMIT);

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        grant = GNT_NONE;
        if (hold_valid_q)                      grant = GNT_HOLD;
        else if (lsu_wb_valid_i && starve_hit) grant = GNT_LSU;
        else if (alu_wb_valid_i)               grant = GNT_ALU;
        else if (lsu_wb_valid_i)               grant = GNT_LSU;
    end

    always_comb begin
        wb_dst  = '0;
        wb_data = '0;
        case (grant)
            GNT_HOLD: begin wb_dst = hold_dst_q;    wb_data = hold_data_q;    end
            GNT_LSU:  begin wb_dst = lsu_wb_dst_i;  wb_data = lsu_wb_data_i;  end
            GNT_ALU:  begin wb_dst = alu_wb_dst_i;  wb_data = alu_wb_data_i;  end
            default:  begin wb_dst = '0;            wb_data = '0;             end
        endcase
    end

    // Reset gates every handshake and write so nothing is consumed during the reset cycle.
    assign lsu_xfer = !rst && (grant == GNT_LSU);
    assign capture  = !rst && !hold_valid_q && lsu_wb_valid_i && starve_hit && alu_wb_valid_i;

    assign rf_we_o        = !rst && (grant != GNT_NONE) && (wb_dst != 5'd0);
    assign rf_dst_o       = wb_dst;
    assign rf_dst_d_o     = wb_data;
    assign lsu_wb_ready_o = lsu_xfer;
    assign wb_stall_o     = capture;
    assign raw_stall_o    = !rst &&
                            (((rf_src1_i != 5'd0) && pending_q[rf_src1_i]) ||
                             ((rf_src2_i != 5'd0) && pending_q[rf_src2_i]));

    always_comb begin
        hold_valid_d = capture;
        hold_dst_d   = hold_dst_q;
        hold_data_d  = hold_data_q;
        if (capture) begin
            hold_dst_d  = alu_wb_dst_i;
            hold_data_d = alu_wb_data_i;
        end

        starve_cnt_d = starve_cnt_q;
        if (lsu_xfer)
            starve_cnt_d = 3'd0;
        else if (lsu_wb_valid_i && (starve_cnt_q < LIMIT))
            starve_cnt_d = starve_cnt_q + 3'd1;

        // Clear before set so a same-cycle issue to the returning register stays pending.
        pending_d = pending_q;
        if (lsu_xfer)
            pending_d[lsu_wb_dst_i] = 1'b0;
        if (lsu_issue_i && (lsu_issue_dst_i != 5'd0))
            pending_d[lsu_issue_dst_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_dst_q   <= '0;
            hold_data_q  <= '0;
            starve_cnt_q <= '0;
            pending_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_dst_q   <= hold_dst_d;
            hold_data_q  <= hold_data_d;
            starve_cnt_q <= starve_cnt_d;
            pending_q    <= pending_d;
        end
    end

endmodule
